// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage view of the hazard/forwarding controller: decoded fields of the
// instruction in ID plus the stall, bubble and forward-select results.
interface hazard_fwd_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wreg;
    logic             id_m2reg;
    logic [4:0]       id_destR;
    logic             stall;
    logic             bubble;
    logic [1:0]       id_FWA;
    logic [1:0]       id_FWB;
    logic [CNT_W-1:0] stall_cnt;

    // Decoder side: drives the ID fields, consumes the hazard results.
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_destR,
        input  stall, bubble, id_FWA, id_FWB, stall_cnt
    );

    // Controller side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_destR,
        output stall, bubble, id_FWA, id_FWB, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline.
// Tracks shadow copies of the EX and MEM write state and resolves ID sources.
module hazard_fwd_ctrl #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_fwd_ctrl_if.slave bus
);
    typedef struct packed {
        logic       v;
        logic       wreg;
        logic       m2reg;
        logic [4:0] dest;
    } shadow_t;

    shadow_t          ex_reg;
    shadow_t          ex_next;
    shadow_t          mem_reg;

    logic [1:0][4:0]  src;
    logic [1:0]       src_checked;
    logic [1:0]       m_ex;
    logic [1:0]       m_mem;
    logic [1:0][1:0]  fwd_sel;
    logic             stall;

    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    assign src[0]      = bus.id_rs;
    assign src[1]      = bus.id_rt;
    assign src_checked = {bus.id_valid & bus.id_use_rt, bus.id_valid & bus.id_use_rs};

    // Per-operand producer matches; register $0 never carries a dependency.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign m_ex[gi]  = src_checked[gi] & ex_reg.v & ex_reg.wreg
                             & (ex_reg.dest == src[gi]) & (src[gi] != 5'd0);
            assign m_mem[gi] = src_checked[gi] & mem_reg.v & mem_reg.wreg
                             & (mem_reg.dest == src[gi]) & (src[gi] != 5'd0);

            if (FWD_EN) begin : g_fwd
                // The EX producer is the younger one, so it wins over MEM.
                assign fwd_sel[gi] = m_ex[gi]  ? 2'b01 :
                                     m_mem[gi] ? 2'b10 : 2'b00;
            end else begin : g_nofwd
                assign fwd_sel[gi] = 2'b00;
            end
        end
    endgenerate

    generate
        if (FWD_EN) begin : g_stall_fwd
            // Only a load in EX cannot be bypassed in time.
            assign stall = (|m_ex) & ex_reg.m2reg;
        end else begin : g_stall_nofwd
            assign stall = (|m_ex) | (|m_mem);
        end
    endgenerate

    always_comb begin
        ex_next = '0;
        if (!stall && bus.id_valid) begin
            ex_next.v     = 1'b1;
            ex_next.wreg  = bus.id_wreg;
            ex_next.m2reg = bus.id_m2reg;
            ex_next.dest  = bus.id_destR;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_reg        <= '0;
            mem_reg       <= '0;
            stall_cnt_reg <= '0;
        end else begin
            ex_reg        <= ex_next;
            mem_reg       <= ex_reg;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign bus.stall     = stall;
    assign bus.bubble    = stall;
    assign bus.id_FWA    = fwd_sel[0];
    assign bus.id_FWB    = fwd_sel[1];
    assign bus.stall_cnt = stall_cnt_reg;
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage MIPS pipeline; sits beside the ID stage.
- Keeps its own shadow copy of the destination and write-control state of the instructions in EX and MEM.
- Each cycle it compares the decoding instruction's sources against the shadow copies and drives:
  - the forwarding selects (id_FWA/id_FWB) that are registered with ID/EX and consumed by the EX-stage operand muxes;
  - the stall/bubble controls for PC, IF/ID and ID/EX.
- Includes a saturating stall-cycle counter for performance debug.

Parameters:
- FWD_EN, 1, 1 = forwarding enabled (stall only on load-use); 0 = no forwarding (stall until producer has left MEM).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- id_valid  input  1  ID holds a real instruction (0 = bubble/nop).
- id_rs  input  5  source register A of ID instruction.
- id_rt  input  5  source register B of ID instruction.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt (includes store data).
- id_wreg  input  1  ID instruction writes the register file.
- id_m2reg  input  1  ID instruction is a load.
- id_destR  input  5  destination register of ID instruction (already rt/rd selected).
- stall  output  1  hold PC and IF/ID this cycle.
- bubble  output  1  load a nop into ID/EX this cycle (equals stall).
- id_FWA  output  2  operand A select for EX: 00 register value, 01 mem_aluR, 10 wb_dest, 11 reserved (never driven).
- id_FWB  output  2  operand B select, same encoding.
- stall_cnt  output  CNT_W  number of stalled cycles since reset, saturating.

Behaviour:
- Shadow registers: ex_v, ex_wreg, ex_m2reg, ex_dest (EX stage); mem_v, mem_wreg, mem_dest (MEM stage).
- Update on each rising clk:
  - MEM shadow ← EX shadow.
  - EX shadow ← ID inputs when stall=0 and id_valid=1; otherwise EX shadow is cleared (v=0, wreg=0, m2reg=0, dest=0).
- Reset: all shadows cleared; stall_cnt=0. Outputs at reset: stall=0, bubble=0, id_FWA=00, id_FWB=00.
- Match terms are combinational from the current shadows and ID inputs:
  - mEX(r) = ex_v & ex_wreg & (ex_dest==r) & (r!=0)
  - mMEM(r) = mem_v & mem_wreg & (mem_dest==r) & (r!=0)
  - A source r is checked only when id_valid and its id_use_* bit is 1.
- FWD_EN=1:
  - Forward select per operand: mEX → 01 (producer reaches MEM when consumer reaches EX); else mMEM → 10; else 00.
  - EX has priority over MEM when both match.
  - Load-use stall when (mEX(rs)&use_rs | mEX(rt)&use_rt) & ex_m2reg. This lasts exactly 1 cycle: after the bubble the load is in MEM, and the select becomes 10.
- FWD_EN=0:
  - id_FWA/id_FWB are always 00.
  - stall = any checked source has mEX or mMEM.
  - Maximum 2 consecutive stall cycles per dependency.
- The register file is write-through (WB write visible to same-cycle ID read), so WB-stage producers never cause a stall or forward.
- While stall=1, the selects are don't-care: ID/EX loads a bubble.
- bubble = stall, same cycle, combinational.
- stall_cnt increments on each clk edge where stall=1; it holds at all-ones.
- Reset asserted mid-stall: stall drops asynchronously; shadows are cleared so no false hazards after release.
- id_valid=0: no stall and selects 00, regardless of shadows.

Test Plan:
1. FWD_EN=1: add $3 in ID, next cycle sub reads $3 as rs → id_FWA=01, stall=0. One cycle later a third instruction reads $3 as rt → id_FWB=10.
2. FWD_EN=1: lw $5 followed immediately by add reading $5 as rs → stall=1 and bubble=1 for exactly 1 cycle. Next cycle id_FWA=10, stall=0, stall_cnt=1.
3. FWD_EN=1: producers of $4 in both EX and MEM, consumer reads $4 as rs → id_FWA=01 (EX priority). Consumer reading $0 with writer dest $0 → id_FWA=00, no stall.
4. FWD_EN=0: add $7 then add reading $7 → stall high for 2 cycles, then low; stall_cnt=2; selects remain 00.
5. Assert rst during the load-use stall of scenario 2 → stall=0 immediately and stall_cnt=0. After release, an instruction reading $5 gets no stall and select 00.
6. Saturation (CNT_W=4): hold a load-use pattern for 20 stall cycles → stall_cnt stops at 15.
